// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector:
// maximum pattern width and the KMP-style transition/border helpers.
package seq_det_pkg;

    localparam int SEQ_MAX_W = 16;
    localparam int SEQ_IDX_W = $clog2(SEQ_MAX_W);

    // Length of the longest proper border (suffix that is also a prefix).
    // Character i of the pattern is pattern[pat_w-1-i] (MSB arrives first).
    function automatic int seq_border(input logic [SEQ_MAX_W-1:0] pattern,
                                      input int pat_w);
        int best;
        bit ok;
        best = 0;
        for (int l = 1; l < SEQ_MAX_W; l++) begin
            if (l < pat_w) begin
                ok = 1'b1;
                for (int j = 0; j < SEQ_MAX_W; j++) begin
                    if (j < l) begin
                        if (pattern[SEQ_IDX_W'(pat_w - 1 - j)] != pattern[SEQ_IDX_W'(l - 1 - j)])
                            ok = 1'b0;
                    end
                end
                if (ok)
                    best = l;
            end
        end
        return best;
    endfunction

    // Next prefix length after receiving x while holding a prefix of length k.
    // A completed pattern restarts at the border (overlap) or at zero.
    function automatic int seq_next_state(input int k,
                                          input logic x,
                                          input logic [SEQ_MAX_W-1:0] pattern,
                                          input int pat_w,
                                          input bit overlap);
        logic [SEQ_MAX_W-1:0] s;
        int best;
        bit ok;
        if (k == pat_w - 1 && x == pattern[0])
            return overlap ? seq_border(pattern, pat_w) : 0;
        // s[0..k] is the received window: prefix of length k followed by x
        s = '0;
        for (int i = 0; i < SEQ_MAX_W; i++) begin
            if (i < k)
                s[i] = pattern[SEQ_IDX_W'(pat_w - 1 - i)];
            else if (i == k)
                s[i] = x;
        end
        best = 0;
        for (int l = 1; l < SEQ_MAX_W; l++) begin
            if (l <= k + 1 && l < pat_w) begin
                ok = 1'b1;
                for (int j = 0; j < SEQ_MAX_W; j++) begin
                    if (j < l) begin
                        if (s[SEQ_IDX_W'(k + 1 - l + j)] != pattern[SEQ_IDX_W'(pat_w - 1 - j)])
                            ok = 1'b0;
                    end
                end
                if (ok)
                    best = l;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_det_match_counter.sv
// Saturating match counter with synchronous clear and saturation flag.
module seq_det_match_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             full;

    assign full = &cnt_q;

    // Next count: clear wins, otherwise count up until all-ones and hold there
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && !full)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign match_cnt = cnt_q;
    assign cnt_sat   = full;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector: prefix-length state register,
// constant transition tables built at elaboration, Mealy/Moore match output.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int             OVERLAP = 1,
    parameter int             MOORE   = 0,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             x,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int             K_W    = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam int             K_N    = 1 << K_W;
    localparam logic [K_W-1:0] K_LAST = K_W'(PAT_W - 1);

    if (PAT_W < 2 || PAT_W > SEQ_MAX_W || CNT_W < 1) begin : g_bad_param
        $error("seq_detect_param: PAT_W must be 2..16 and CNT_W >= 1");
    end

    // Transition tables indexed by current prefix length, one per input value
    logic [K_W-1:0] next0_lut [K_N];
    logic [K_W-1:0] next1_lut [K_N];

    for (genvar gi = 0; gi < K_N; gi++) begin : g_lut
        if (gi < PAT_W) begin : g_live
            assign next0_lut[gi] = K_W'(seq_next_state(gi, 1'b0, SEQ_MAX_W'(PATTERN), PAT_W, OVERLAP != 0));
            assign next1_lut[gi] = K_W'(seq_next_state(gi, 1'b1, SEQ_MAX_W'(PATTERN), PAT_W, OVERLAP != 0));
        end else begin : g_pad
            assign next0_lut[gi] = '0;
            assign next1_lut[gi] = '0;
        end
    end

    logic [K_W-1:0] k_q;
    logic [K_W-1:0] k_d;
    logic           match_hit;

    // A match is the completing bit sampled while holding the full-minus-one prefix
    assign match_hit = en & ~clr & (k_q == K_LAST) & (x == PATTERN[0]);

    // Next prefix length: clear wins, disabled cycles hold
    always_comb begin
        k_d = k_q;
        if (clr)
            k_d = '0;
        else if (en)
            k_d = x ? next1_lut[k_q] : next0_lut[k_q];
    end

    // Prefix-length state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            k_q <= '0;
        else
            k_q <= k_d;
    end

    if (MOORE != 0) begin : g_moore
        logic z_q;
        logic z_d;

        // Registered pulse: exactly the cycle after the completing bit
        always_comb begin
            z_d = match_hit;
        end

        // Moore output register; clr discards a pending pulse
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                z_q <= 1'b0;
            else
                z_q <= z_d;
        end

        assign z = z_q;
    end else begin : g_mealy
        assign z = match_hit;
    end

    seq_det_match_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .inc       (match_hit),
        .match_cnt (match_cnt),
        .cnt_sat   (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: four instances (Mealy overlap,
// Mealy non-overlap, Moore, 2-bit counter). Stimulus pushes the hand-derived
// per-cycle expectation; a negedge monitor pops and compares.
module tb_seq_detect_param;

    typedef struct {
        logic       z;
        logic [7:0] cnt;
        logic       sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_v  [4];
    logic x_v   [4];
    logic clr_v [4];
    logic z_v   [4];
    logic sat_v [4];
    logic [7:0] cnt_v [4];
    logic [1:0] cnt3;

    exp_t exp_q [4][$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .MOORE(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr_v[0]), .en(en_v[0]), .x(x_v[0]),
        .z(z_v[0]), .match_cnt(cnt_v[0]), .cnt_sat(sat_v[0]));

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .MOORE(0), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr_v[1]), .en(en_v[1]), .x(x_v[1]),
        .z(z_v[1]), .match_cnt(cnt_v[1]), .cnt_sat(sat_v[1]));

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .MOORE(1), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr_v[2]), .en(en_v[2]), .x(x_v[2]),
        .z(z_v[2]), .match_cnt(cnt_v[2]), .cnt_sat(sat_v[2]));

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .MOORE(0), .CNT_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .clr(clr_v[3]), .en(en_v[3]), .x(x_v[3]),
        .z(z_v[3]), .match_cnt(cnt3), .cnt_sat(sat_v[3]));

    assign cnt_v[3] = {6'b0, cnt3};

    // Monitor: every expectation pushed for a cycle is checked at that cycle's negedge
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (exp_q[d].size() > 0) begin
                mon_e = exp_q[d].pop_front();
                n_checks = n_checks + 3;
                if (z_v[d] !== mon_e.z) begin
                    n_fail = n_fail + 1;
                    $display("FAIL dut%0d z cyc %0d: got %0b expected %0b", d, cyc, z_v[d], mon_e.z);
                end
                if (cnt_v[d] !== mon_e.cnt) begin
                    n_fail = n_fail + 1;
                    $display("FAIL dut%0d match_cnt cyc %0d: got %0d expected %0d", d, cyc, cnt_v[d], mon_e.cnt);
                end
                if (sat_v[d] !== mon_e.sat) begin
                    n_fail = n_fail + 1;
                    $display("FAIL dut%0d cnt_sat cyc %0d: got %0b expected %0b", d, cyc, sat_v[d], mon_e.sat);
                end
                $display("dut%0d cyc %0d en=%0b clr=%0b x=%0b z=%0b cnt=%0d sat=%0b", d, cyc,
                         en_v[d], clr_v[d], x_v[d], z_v[d], cnt_v[d], sat_v[d]);
            end
        end
    end

    // Drive one instance's inputs for the current cycle and queue its expectation
    task automatic set_in(input int d, input logic en, input logic clr, input logic x,
                          input logic ez, input logic [7:0] ec, input logic es);
        exp_t e;
        en_v[d]  = en;
        clr_v[d] = clr;
        x_v[d]   = x;
        e.z   = ez;
        e.cnt = ec;
        e.sat = es;
        exp_q[d].push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sampled bit (en=1, clr=0) on an 8-bit-counter instance
    task automatic b(input int d, input logic x, input logic ez, input logic [7:0] ec);
        set_in(d, 1'b1, 1'b0, x, ez, ec, 1'b0);
        step();
    endtask

    // Idle cycle (en=0) on an 8-bit-counter instance
    task automatic idle(input int d, input logic ez, input logic [7:0] ec);
        set_in(d, 1'b0, 1'b0, 1'b0, ez, ec, 1'b0);
        step();
    endtask

    initial begin
        logic [3:0] pat;
        pat = 4'b1011;
        for (int d = 0; d < 4; d++) begin
            en_v[d]  = 1'b0;
            clr_v[d] = 1'b0;
            x_v[d]   = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Reset state of every instance
        for (int d = 0; d < 4; d++)
            set_in(d, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        step();

        // Mealy, overlap: 1,0,1,1,0,1,1 matches on bits 4 and 7
        b(0, 1, 0, 0); b(0, 0, 0, 0); b(0, 1, 0, 0); b(0, 1, 1, 0);
        b(0, 0, 0, 1); b(0, 1, 0, 1); b(0, 1, 1, 1);
        idle(0, 0, 2);

        // Mealy, no overlap: only bit 4 matches, leaves k=1 so 0,1,1 completes
        b(1, 1, 0, 0); b(1, 0, 0, 0); b(1, 1, 0, 0); b(1, 1, 1, 0);
        b(1, 0, 0, 1); b(1, 1, 0, 1); b(1, 1, 0, 1);
        idle(1, 0, 1);
        b(1, 0, 0, 1); b(1, 1, 0, 1); b(1, 1, 1, 1);
        idle(1, 0, 2);

        // Moore: pulse in the cycle after bit 4, one cycle wide with en low
        b(2, 1, 0, 0); b(2, 0, 0, 0); b(2, 1, 0, 0); b(2, 1, 0, 0);
        idle(2, 1, 1);
        idle(2, 0, 1);

        // 2-bit counter: 1011 x5 -> counts 1,2,3,3,3 with saturation at 3
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) begin
                set_in(3, 1'b1, 1'b0, pat[3-i], (i == 3), 8'((r > 3) ? 3 : r), (r >= 3));
                step();
            end
        end
        set_in(3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1);
        step();

        // clr with a completing-style bit present: discarded, count cleared
        set_in(0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0);
        step();
        // en gap: 1,0,1 then three ignored toggling bits, then 1 completes
        b(0, 1, 0, 0); b(0, 0, 0, 0); b(0, 1, 0, 0);
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0); step();
        set_in(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0); step();
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0); step();
        b(0, 1, 1, 0);
        idle(0, 0, 1);

        // Async reset mid-sequence (k=3): count must drop without a clock edge
        b(0, 1, 0, 1); b(0, 0, 0, 1); b(0, 1, 0, 1);
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // A fresh 1 does not match; k=1 afterwards so 0,1,1 completes
        b(0, 1, 0, 0); b(0, 0, 0, 0); b(0, 1, 0, 0); b(0, 1, 1, 0);
        idle(0, 0, 1);

        // Same with clr instead of reset
        b(0, 1, 0, 1); b(0, 0, 0, 1); b(0, 1, 0, 1);
        set_in(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
        step();
        b(0, 1, 0, 0); b(0, 0, 0, 0); b(0, 1, 0, 0); b(0, 1, 1, 0);
        idle(0, 0, 1);

        step();
        for (int d = 0; d < 4; d++) begin
            n_checks = n_checks + 1;
            if (exp_q[d].size() != 0) begin
                n_fail = n_fail + 1;
                $display("FAIL dut%0d drain: got %0d pending expected 0", d, exp_q[d].size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector. Successor to the fixed 1-bit-input FSM exercises.
- Pattern, length, overlap mode and output style (Mealy or Moore) are all set by parameters.
- Adds an input qualifier, a synchronous clear and a saturating match counter.
- Sits on a serial input stream; drives a match pulse plus a running match count for status logic.

Parameters:
- PAT_W, 4: pattern length in bits, legal range 2..16.
- PATTERN, 4'b1011: target sequence; bit PAT_W-1 is received first.
- OVERLAP, 1: 1 = matches may share bits; 0 = detector restarts empty after each match.
- MOORE, 0: 0 = Mealy output (combinational z); 1 = Moore output (registered z).
- CNT_W, 8: width of the match counter.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- clr  input  1  synchronous clear of detector state, counter and z; has priority over en.
- en  input  1  qualifies x; when low, x is ignored and state holds.
- x  input  1  serial data bit.
- z  output  1  match pulse.
- match_cnt  output  CNT_W  number of matches since reset or clr; saturating.
- cnt_sat  output  1  high while match_cnt equals all-ones.

Behaviour:
- State k (0..PAT_W-1) is the length of the longest received suffix that equals a prefix of PATTERN. Width is $clog2(PAT_W).
- Per sampled bit (en=1, clr=0):
  - If x extends the prefix and k+1 < PAT_W: k <= k+1.
  - If x completes the pattern: a match occurs.
    - OVERLAP=1: k <= length of the longest proper border of PATTERN.
    - OVERLAP=0: k <= 0.
  - Otherwise (mismatch): k <= longest suffix of (prefix_k, x) that is also a prefix of PATTERN, i.e. KMP fallback.
- Mealy (MOORE=0): z = en & ~clr & (k==PAT_W-1) & (x==PATTERN[0]). Asserts in the same cycle as the completing bit.
- Moore (MOORE=1): z is a register, set in the cycle after the completing bit is sampled. Always exactly one cycle wide, regardless of en.
- Counter: match_cnt increments by 1 on each match. At all-ones it holds and cnt_sat=1; no wrap.
- clr=1 at a rising edge: k, match_cnt and the Moore z register go to 0. A bit presented in that cycle is discarded and not counted.
- en=0: k and match_cnt hold; Mealy z=0; a Moore z pulse already pending still completes.
- Reset values (rst_n low, asynchronous): k=0, match_cnt=0, cnt_sat=0, Moore z=0.
- Deassertion of rst_n is not assumed synchronised by this block.
- Reset mid-sequence: all partial-match progress is lost; the first match needs PAT_W fresh bits.
- Elaboration check: assert if PAT_W is outside 2..16 or CNT_W < 1.

Decomposition:
- Shared package seq_det_pkg holds:
  - constant SEQ_MAX_W = 16;
  - automatic function seq_next_state(k, x, pattern, pat_w, overlap). It computes the transition at elaboration or combinationally.
  - automatic function seq_border(pattern, pat_w).
- Sub-module seq_det_match_counter (CNT_W): increment, clr, saturation and cnt_sat.
- The top level holds the state register and the Mealy/Moore output selection.

Test Plan:
- Defaults (1011, OVERLAP=1, Mealy); after reset, en=1, drive x=1,0,1,1,0,1,1 -> z high combinationally on bit 4 and bit 7; match_cnt=2.
- Same stream with OVERLAP=0 -> z high on bit 4 only; match_cnt=1; k=1 after bit 7.
- MOORE=1, defaults otherwise, stream 1,0,1,1 -> z low during bit 4; high for exactly the next cycle; match_cnt=1 one edge after bit 4.
- Stream 1,0,1 with en=1, then en=0 for 3 cycles with x toggling, then en=1, x=1 -> exactly one match; count=1; z=0 throughout the en=0 gap.
- CNT_W=2, repeated 1011 x5 -> match_cnt goes 1,2,3,3,3; cnt_sat rises with the third match.
- Stream 1,0,1 then rst_n low mid-cycle (async), release, drive 1 -> no match; k=1, match_cnt=0. Repeat using clr instead of rst_n -> identical result.
